// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-access controller.
// Mode bit positions follow the {CPOL, CPHA} packing of the mode input.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ADDR  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DATA  = 3'd4,
        ST_HOLD  = 3'd5,
        ST_DONE  = 3'd6
    } spi_state_e;

    localparam int CPOL_IDX    = 1;
    localparam int CPHA_IDX    = 0;
    localparam int FRAME_BYTES = 2;

    // States in which spi_clk toggles.
    function automatic logic is_shift_state(input spi_state_e s);
        return (s == ST_ADDR) || (s == ST_DATA);
    endfunction

    // States in which the chip select is held asserted.
    function automatic logic cs_active(input spi_state_e s);
        return !((s == ST_IDLE) || (s == ST_DONE));
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timebase and serial clock generator. The counter also paces the
// idle phases of the frame; edge strobes fire only while toggling is enabled.
module spi_clk_gen #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rstb,
    input  logic ena,
    input  logic load,
    input  logic cnt_en,
    input  logic toggle_en,
    input  logic cpol,
    input  logic idle_lvl,
    output logic tick,
    output logic lead,
    output logic trail,
    output logic spi_clk
);

    localparam int CNT_W = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;

    assign tick  = ena & cnt_en & (cnt_q == '0);
    // A leading edge moves spi_clk away from its idle level.
    assign lead  = tick & toggle_en & (clk_q == cpol);
    assign trail = tick & toggle_en & (clk_q != cpol);

    always_comb begin
        cnt_d = cnt_q;
        clk_d = clk_q;
        if (ena) begin
            if (load) begin
                cnt_d = RELOAD;
            end else if (cnt_en) begin
                cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CNT_W'(1);
            end
            if (toggle_en) begin
                if (tick) begin
                    clk_d = ~clk_q;
                end
            end else begin
                clk_d = idle_lvl;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    assign spi_clk = clk_q;

endmodule

// File: rtl/spi_controller.sv
// SPI master issuing two-byte register frames: {wr_rdn, addr} then data.
// Captures the responder's status byte during the address and read data after.
module spi_controller
    import spi_pkg::*;
#(
    parameter int REG_W       = 8,
    parameter int HALF_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             start,
    input  logic             wr_rdn,
    input  logic [REG_W-2:0] addr,
    input  logic [REG_W-1:0] wdata,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [REG_W-1:0] status,
    output logic [REG_W-1:0] rdata,
    output logic             spi_clk,
    output logic             spi_mosi,
    output logic             spi_cs_n,
    input  logic             spi_miso
);

    localparam int BIT_W      = $clog2(REG_W);
    localparam int BYTE_IDX_W = (FRAME_BYTES > 2) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [BIT_W-1:0]      LAST_BIT  = BIT_W'(REG_W - 1);
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(FRAME_BYTES - 1);

    spi_state_e              state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [REG_W-1:0]        tx_q, tx_d;
    logic [REG_W-1:0]        rx_q, rx_d;
    logic [REG_W-1:0]        byte1_q, byte1_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic                    second_q, second_d;
    logic                    mosi_q, mosi_d;
    logic                    cs_n_q, cs_n_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [REG_W-1:0]        status_q, status_d;
    logic [REG_W-1:0]        rdata_q, rdata_d;

    logic             accept;
    logic             cpha;
    logic             tick, lead, trail;
    logic             sample, shift_out, byte_end;
    logic [REG_W-1:0] byte0;

    assign byte0     = {wr_rdn, addr};
    assign accept    = start & (state_q == ST_IDLE);
    assign cpha      = mode_q[CPHA_IDX];
    assign sample    = cpha ? trail : lead;
    assign shift_out = cpha ? lead : trail;
    // Every byte ends on its final trailing edge, which returns spi_clk to idle.
    assign byte_end  = trail & (bit_q == LAST_BIT);

    spi_clk_gen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_clk_gen (
        .clk      (clk),
        .rstb     (rstb),
        .ena      (ena),
        .load     (accept),
        .cnt_en   (state_q != ST_IDLE),
        .toggle_en(is_shift_state(state_q)),
        .cpol     (mode_q[CPOL_IDX]),
        .idle_lvl (mode_d[CPOL_IDX]),
        .tick     (tick),
        .lead     (lead),
        .trail    (trail),
        .spi_clk  (spi_clk)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        byte1_d    = byte1_q;
        bit_d      = bit_q;
        byte_idx_d = byte_idx_q;
        second_d   = second_q;
        mosi_d     = mosi_q;
        status_d   = status_q;
        rdata_d    = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SETUP;
                    mode_d     = mode;
                    byte1_d    = wr_rdn ? wdata : '0;
                    bit_d      = '0;
                    byte_idx_d = '0;
                    second_d   = 1'b0;
                    // With CPHA=0 the MSB must already be on the wire before the first edge.
                    tx_d       = mode[CPHA_IDX] ? byte0 : (byte0 << 1);
                    mosi_d     = mode[CPHA_IDX] ? 1'b0 : byte0[REG_W-1];
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR, ST_DATA: begin
                if (sample) begin
                    rx_d = {rx_q[REG_W-2:0], spi_miso};
                end
                if (trail) begin
                    bit_d = (bit_q == LAST_BIT) ? '0 : bit_q + BIT_W'(1);
                end
                if (byte_end) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        rdata_d = rx_d;
                        state_d = ST_HOLD;
                    end else begin
                        status_d   = rx_d;
                        byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
                        state_d    = ST_GAP;
                        tx_d       = cpha ? byte1_q : (byte1_q << 1);
                        if (!cpha) begin
                            mosi_d = byte1_q[REG_W-1];
                        end
                    end
                end else if (shift_out) begin
                    mosi_d = tx_q[REG_W-1];
                    tx_d   = tx_q << 1;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    second_d = ~second_q;
                    if (second_q) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_DONE;
                    mosi_d  = 1'b0;
                end
            end
            ST_DONE: begin
                if (tick) begin
                    second_d = ~second_q;
                    if (second_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cs_n_d = ~cs_active(state_d);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= ST_IDLE;
            mode_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            byte1_q    <= '0;
            bit_q      <= '0;
            byte_idx_q <= '0;
            second_q   <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= '0;
            rdata_q    <= '0;
        end else if (ena) begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            byte1_q    <= byte1_d;
            bit_q      <= bit_d;
            byte_idx_q <= byte_idx_d;
            second_q   <= second_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            status_q   <= status_d;
            rdata_q    <= rdata_d;
        end
    end

    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign status   = status_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a pin-level responder model with a small register
// file decodes each frame and supplies MISO; results are compared per frame.
module tb_spi_controller;

    localparam int HP = 4;

    logic       clk = 1'b0;
    logic       rstb;
    logic       ena;
    logic       start;
    logic       wr_rdn;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [1:0] mode;
    logic       spi_miso;
    logic       busy, done, spi_clk, spi_mosi, spi_cs_n;
    logic [7:0] status, rdata;

    always #5 clk = ~clk;

    spi_controller #(
        .REG_W      (8),
        .HALF_PERIOD(HP)
    ) dut (
        .clk     (clk),
        .rstb    (rstb),
        .ena     (ena),
        .start   (start),
        .wr_rdn  (wr_rdn),
        .addr    (addr),
        .wdata   (wdata),
        .mode    (mode),
        .busy    (busy),
        .done    (done),
        .status  (status),
        .rdata   (rdata),
        .spi_clk (spi_clk),
        .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n),
        .spi_miso(spi_miso)
    );

    int checks   = 0;
    int failures = 0;

    // Responder / monitor state
    logic       prev_cs  = 1'b1;
    logic       prev_clk = 1'b0;
    logic [1:0] fmode;
    logic [7:0] miso_b0, miso_b1, wjunk;
    logic [15:0] mosi_cap;
    logic [7:0] regs [128];
    int edges, nbits, miso_idx;
    int done_cnt, cs_falls, busy_err, gap_err;
    int we_cnt;
    logic [7:0] we_data;
    int cyc, stall, last_edge_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic miso_bit(input int idx);
        if (idx < 8)  return miso_b0[7-idx];
        if (idx < 16) return miso_b1[15-idx];
        return 1'b0;
    endfunction

    // One clock cycle: observe pins on the falling edge, act as the responder.
    task automatic step();
        logic cs, sck, is_lead, is_samp;
        int in_byte;
        @(negedge clk);
        cyc++;
        if (!ena) stall++;
        cs  = spi_cs_n;
        sck = spi_clk;
        if (done === 1'b1) done_cnt++;
        if (!cs && busy !== 1'b1) busy_err++;
        if (prev_cs && !cs) begin
            cs_falls++;
            edges = 0; nbits = 0; mosi_cap = '0; stall = 0;
            if (!fmode[0]) begin
                spi_miso = miso_bit(0);
                miso_idx = 1;
            end else begin
                miso_idx = 0;
            end
        end else if (!prev_cs && !cs && sck !== prev_clk) begin
            edges++;
            in_byte = ((edges - 1) % 16) + 1;
            if (in_byte > 1 && (cyc - last_edge_cyc - stall) != HP) gap_err++;
            last_edge_cyc = cyc;
            stall = 0;
            is_lead = (sck != fmode[1]);
            is_samp = fmode[0] ? !is_lead : is_lead;
            if (is_samp) begin
                mosi_cap = {mosi_cap[14:0], spi_mosi};
                nbits++;
                if (nbits == 8) miso_b1 = mosi_cap[7] ? wjunk : regs[mosi_cap[6:0]];
            end else begin
                spi_miso = miso_bit(miso_idx);
                miso_idx++;
            end
        end else if (!prev_cs && cs) begin
            if (nbits == 16 && mosi_cap[15]) begin
                regs[mosi_cap[14:8]] = mosi_cap[7:0];
                we_cnt++;
                we_data = mosi_cap[7:0];
            end
        end
        prev_cs  = cs;
        prev_clk = sck;
    endtask

    task automatic run_frame(input string name, input logic w, input logic [6:0] a,
                             input logic [7:0] d, input logic [1:0] m, input logic [7:0] st,
                             input logic [7:0] jk, input int pulse_edge, input bit start_at_done,
                             input int ena_edge, input int rst_edge);
        int n, frz_err;
        logic [7:0] exp_rd;
        logic clk0, mo0;
        int we0;
        bit pulsed, froze, aborted;
        pulsed = 0; froze = 0; aborted = 0; frz_err = 0;
        miso_b0 = st; wjunk = jk; fmode = m; miso_b1 = '0;
        exp_rd = w ? jk : regs[a];
        we0 = we_cnt;
        done_cnt = 0; busy_err = 0; gap_err = 0; cs_falls = 0;
        wr_rdn = w; addr = a; wdata = d; mode = m; start = 1'b1;
        step();
        start = 1'b0;
        mode = 2'($urandom); wr_rdn = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
        n = 0;
        while (done_cnt == 0 && n < 3000 && !aborted) begin
            step();
            n++;
            if (pulse_edge > 0 && edges == pulse_edge && !pulsed) begin
                pulsed = 1;
                start = 1'b1;
                step();
                start = 1'b0;
            end
            if (ena_edge > 0 && edges == ena_edge && !froze) begin
                froze = 1;
                clk0 = spi_clk; mo0 = spi_mosi;
                ena = 1'b0;
                repeat (10) begin
                    step();
                    if (spi_clk !== clk0 || spi_mosi !== mo0) frz_err++;
                end
                ena = 1'b1;
                chk({name, "_frozen_pins"}, frz_err, 0);
            end
            if (rst_edge > 0 && edges == rst_edge) begin
                aborted = 1;
                rstb = 1'b0;
                #1;
                chk({name, "_rst_cs_n"}, spi_cs_n, 1'b1);
                chk({name, "_rst_busy"}, busy, 1'b0);
                chk({name, "_rst_sclk"}, spi_clk, 1'b0);
                chk({name, "_rst_mosi"}, spi_mosi, 1'b0);
                chk({name, "_rst_status"}, status, 8'h00);
                chk({name, "_rst_rdata"}, rdata, 8'h00);
                step();
                rstb = 1'b1;
                step();
            end
        end
        if (!aborted) begin
            chk({name, "_done_seen"}, (done_cnt != 0), 1'b1);
            if (start_at_done) begin
                start = 1'b1;
                step();
                start = 1'b0;
            end
            n = 0;
            while (busy === 1'b1 && n < 200) begin
                step();
                n++;
            end
            repeat (4) step();
            chk({name, "_byte0"}, mosi_cap[15:8], {w, a});
            chk({name, "_byte1"}, mosi_cap[7:0], w ? d : 8'h00);
            chk({name, "_edges"}, edges, 32);
            chk({name, "_edge_gap_err"}, gap_err, 0);
            chk({name, "_done_pulses"}, done_cnt, 1);
            chk({name, "_cs_falls"}, cs_falls, 1);
            chk({name, "_busy_gap"}, busy_err, 0);
            chk({name, "_status"}, status, st);
            chk({name, "_rdata"}, rdata, exp_rd);
            chk({name, "_cs_n_after"}, spi_cs_n, 1'b1);
            chk({name, "_busy_after"}, busy, 1'b0);
            if (w) begin
                chk({name, "_we_pulse"}, we_cnt, we0 + 1);
                chk({name, "_we_data"}, we_data, d);
            end
            $display("frame %s w=%0d addr=%02h wdata=%02h mode=%0d mosi=%04h status=%02h rdata=%02h",
                     name, w, a, d, m, mosi_cap, status, rdata);
        end else begin
            $display("frame %s aborted by reset at edge %0d", name, rst_edge);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) regs[i] = 8'h00;
        rstb = 1'b0; ena = 1'b1; start = 1'b0; wr_rdn = 1'b0;
        addr = '0; wdata = '0; mode = 2'b00; spi_miso = 1'b0; fmode = 2'b00;
        edges = 0; nbits = 0; miso_idx = 0; mosi_cap = '0; we_cnt = 0; we_data = '0;
        cyc = 0; stall = 0; last_edge_cyc = 0;
        miso_b0 = '0; miso_b1 = '0; wjunk = '0;
        repeat (3) step();
        chk("reset_cs_n", spi_cs_n, 1'b1);
        chk("reset_sclk", spi_clk, 1'b0);
        chk("reset_mosi", spi_mosi, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_status", status, 8'h00);
        chk("reset_rdata", rdata, 8'h00);
        rstb = 1'b1;
        repeat (2) step();

        run_frame("m0_write", 1'b1, 7'h05, 8'hA5, 2'b00, 8'($urandom), 8'($urandom), 0, 0, 0, 0);

        regs[7'h12] = 8'h5A;
        run_frame("m3_read", 1'b0, 7'h12, 8'hFF, 2'b11, 8'h3C, 8'h00, 0, 0, 0, 0);
        chk("m3_read_status_3c", status, 8'h3C);
        chk("m3_read_rdata_5a", rdata, 8'h5A);

        for (int m = 0; m < 4; m++) begin
            run_frame($sformatf("loop_wr_m%0d", m), 1'b1, 7'h07, 8'hC3, 2'(m), 8'($urandom), 8'($urandom), 0, 0, 0, 0);
            chk($sformatf("loop_reg7_m%0d", m), regs[7], 8'hC3);
            regs[7] = 8'hC3;
            run_frame($sformatf("loop_rd_m%0d", m), 1'b0, 7'h07, 8'h00, 2'(m), 8'($urandom), 8'h00, 0, 0, 0, 0);
            chk($sformatf("loop_rdata_m%0d", m), rdata, 8'hC3);
            regs[7] = 8'h00;
        end

        for (int i = 0; i < 10; i++) begin
            run_frame($sformatf("rnd%0d", i), 1'($urandom), 7'($urandom_range(0, 7)), 8'($urandom),
                      2'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 0);
        end

        run_frame("start_ignored", 1'b1, 7'h2A, 8'h96, 2'b01, 8'h6E, 8'h19, 3, 1'b1, 0, 0);

        run_frame("ena_freeze", 1'b1, 7'h33, 8'h4B, 2'b10, 8'hD2, 8'h81, 0, 0, 5, 0);

        run_frame("rst_abort", 1'b1, 7'h44, 8'hEE, 2'b11, 8'hE7, 8'h77, 0, 0, 0, 20);
        run_frame("after_rst", 1'b1, 7'h01, 8'h11, 2'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 0);
        chk("after_rst_reg1", regs[1], 8'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameters: REG_W, default 8, register width; HALF_PERIOD, default 4, clk cycles per spi_clk half-period (legal range 2..255).
REQ-002 clk  input  1  system clock; all logic on posedge.
REQ-003 rstb  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  global enable; when low, all state, counters and outputs hold.
REQ-005 start  input  1  one-cycle request; accepted only in IDLE.
REQ-006 wr_rdn  input  1  1 = write frame, 0 = read frame.
REQ-007 addr  input  REG_W-1  target register address.
REQ-008 wdata  input  REG_W  write payload.
REQ-009 mode  input  2  {CPOL, CPHA}; sampled on accepted start.
REQ-010 busy  output  1  high from accepted start until done.
REQ-011 done  output  1  one-cycle pulse at frame end.
REQ-012 status  output  REG_W  byte shifted in on MISO during the address byte.
REQ-013 rdata  output  REG_W  byte shifted in on MISO during the data byte (read frames; also updated on write frames).
REQ-014 spi_clk, spi_mosi, spi_cs_n  output  1 each; spi_miso  input  1.

Function
REQ-015 The frame SHALL be spi_cs_n low, then byte0 = {wr_rdn, addr}, then byte1 = wdata (write) or 0x00 (read), both MSB first.
REQ-016 FSM states: IDLE, SETUP, ADDR, GAP, DATA, HOLD, DONE.
REQ-017 IDLE: spi_cs_n=1, spi_clk=latched CPOL; on start & ena, latch inputs, go to SETUP, and drive spi_cs_n=0 on the next cycle.
REQ-018 SETUP: HALF_PERIOD cycles with spi_clk idle; MOSI = byte0 MSB when CPHA=0.
REQ-019 ADDR/DATA: 16 spi_clk edges per byte, each HALF_PERIOD cycles apart; the sample edge is the leading edge when CPHA=0 and the trailing edge when CPHA=1.
REQ-020 MISO SHALL be captured on the clk cycle that produces each sample edge; MOSI SHALL advance on each change edge, never on a sample edge.
REQ-021 After the 8th sample, spi_clk SHALL return to CPOL, and the shift-in register SHALL be copied to status (ADDR) or rdata (DATA).
REQ-022 GAP: 2*HALF_PERIOD cycles, spi_clk idle and spi_cs_n low, so the responder can load its transmit buffer; MOSI = byte1 MSB when CPHA=0.
REQ-023 HOLD: HALF_PERIOD cycles, then spi_cs_n=1; DONE then lasts 2*HALF_PERIOD cycles with spi_cs_n high, pulses done on its first cycle, and returns to IDLE.
REQ-024 busy SHALL be low only in IDLE; start while busy SHALL be ignored, with no queueing.
REQ-025 The half-period counter SHALL count down HALF_PERIOD-1..0 and reload on terminal count; the bit counter SHALL wrap 7->0 per byte.
REQ-026 A start in the same cycle as done SHALL be ignored; the earliest accepted start is the cycle after the return to IDLE.
REQ-027 A mode change during a frame SHALL have no effect until the next accepted start.

Reset
REQ-028 rstb low at any time, including mid-frame, SHALL immediately force: state IDLE, spi_cs_n=1, spi_clk=0, spi_mosi=0, busy=0, done=0, status=0, rdata=0, counters=0, latched mode=0.
REQ-029 After reset release, the first frame SHALL start cleanly, with no partial frame resumed.

Structure
REQ-030 Package spi_pkg SHALL hold the FSM state enum, the CPOL/CPHA bit indices and the frame byte count (2).
REQ-031 One sub-module, spi_clk_gen, SHALL hold the half-period counter and emit leading/trailing edge strobes plus spi_clk, gated by an enable from the FSM.

Verification
REQ-032 Mode 0, write, addr=0x05, wdata=0xA5 -> MOSI bytes 0x85, 0xA5; 32 spi_clk edges; one done pulse; spi_cs_n high afterwards.
REQ-033 Mode 3, read, addr=0x12, MISO model returns 0x3C then 0x5A -> MOSI 0x12, 0x00; status=0x3C, rdata=0x5A at done.
REQ-034 Loopback against spi_peripheral in all 4 modes: write 0xC3 to addr 0x07 -> peripheral we pulse with wdata=0xC3; read addr 0x07 with rdata=0xC3 driven -> controller rdata=0xC3.
REQ-035 start pulsed during ADDR and again coincident with done -> neither accepted; exactly one frame observed.
REQ-036 rstb asserted mid-DATA -> same cycle spi_cs_n=1, busy=0; a subsequent write of 0x11 to addr 0x01 completes correctly.
REQ-037 ena held low for 10 cycles mid-ADDR -> spi_clk, spi_mosi and the counters frozen; the frame then completes with correct bytes.
